eth_axis_rx_buffer: RTL
=======================

// Module: eth_axis_rx_buffer
// PURPOSE
// - Ethernet RX-side byte packer: takes the 8-bit AXI-Stream from the MAC RX path and packs it into 32-bit words for the uDMA RX channel.
// - Mirror of the TX 32->8 unpacker: same lane order, byte_count encoding and tlast/tuser meaning, so RX words are directly TX-compatible.
// - Single clock domain. Any CDC FIFO sits outside this block.
// PARAMETERS
// - MAX_FRAME_BYTES  1522  max accepted bytes per frame; longer frames are truncated and flagged (range 4..65535)
// PORTS
// - clk_i              in   1   clock
// - rstn_i             in   1   reset, synchronous, active-low
// - s_axis_tdata       in   8   RX byte from MAC
// - s_axis_tvalid      in   1   byte valid
// - s_axis_tlast       in   1   last byte of frame
// - s_axis_tuser       in   1   frame error flag from MAC (may be set on any byte)
// - s_axis_tready      out  1   byte accepted when tvalid&tready
// - m_axis_tdata       out  32  packed word; first byte of word in [7:0]
// - m_axis_byte_count  out  2   index of last valid byte lane (3 = full word)
// - m_axis_tvalid      out  1   word valid
// - m_axis_tlast       out  1   word holds last byte of frame
// - m_axis_tuser       out  1   frame error, OR of s_axis_tuser over the word's bytes, or truncation
// - m_axis_tready      in   1   downstream accepts word
// BEHAVIOUR
// - Reset (rstn_i low at posedge): all m_axis_* = 0, s_axis_tready = 0 while reset is asserted, lane index = 0, length = 0, state = PACK.
//   Any partial word or held output word is discarded. Reset mid-frame drops the rest of that frame.
// - Datapath registers:
//   - assembly reg: 24b data, 2b lane index idx, 1b err accumulator
//   - output reg: 32b data + byte_count/tlast/tuser/valid
// - s_axis_tready = !m_axis_tvalid | m_axis_tready (held at 0 in reset).
//   Sustains 1 byte/clk when the downstream is always ready.
// - PACK, on each accepted byte:
//   - Byte goes to lane idx. err_acc |= tuser.
//   - idx 0..2 and !tlast: store byte, idx++.
//   - idx==3 or tlast: load output reg next cycle.
//     - data = assembled lanes + this byte; lanes above idx = 0.
//     - byte_count = idx; tlast = s_tlast; tuser = err_acc|s_tuser.
//     - Clear idx and err_acc.
// - Latency: word valid on m_axis in the cycle after its completing byte is accepted.
// - Output reg holds its value until m_axis_tready. Loading a new word in the same cycle as the old one is taken is allowed: no bubble.
// - Frame length counter: counts accepted bytes, cleared on tlast.
//   - When the MAX_FRAME_BYTES-th byte is accepted without tlast: emit it as a tlast word with tuser=1, then go to DISCARD.
// - DISCARD: s_axis_tready = 1, bytes are dropped, no output.
//   - Accepted byte with tlast: go to PACK, length = 0, idx = 0.
// - tlast on the 4th lane -> byte_count=3. tlast on lane 0 -> byte_count=0, data[31:8]=0.
// - Frames of 1 byte are legal. Zero-length frames cannot exist: tlast always comes with a byte.
// - m_axis_tuser is valid on every word. The consumer samples it on the tlast word.
// CONFIGURATION
// - ETH_RX_BUFFER_STATS_EN defined adds ports:
//   - stat_clr_i           in  1   sync clear of both counters; wins over an increment in the same cycle
//   - stat_frames_o        out 32  +1 per accepted tlast output word (m_tvalid&m_tready&m_tlast), wraps
//   - stat_err_frames_o    out 32  +1 per accepted tlast word with tuser=1, wraps
//   Both counters reset to 0.
// - Not defined: ports and counters absent; datapath behaviour is identical.
// TESTING
// - Reset, then bytes 0x11,0x22,0x33,0x44 (last on 0x44), m_tready=1 -> one word 0x44332211, byte_count=3, tlast=1, tuser=0, 1 cycle after the last byte.
// - 6-byte frame 01..06 -> words 0x04030201 (bc=3, tlast=0) then 0x00000605 (bc=1, tlast=1).
// - s_tuser=1 on byte 2 of a 5-byte frame -> word 0 tuser=1, word 1 tuser=0, tlast=1, bc=0.
// - MAX_FRAME_BYTES=8, 12-byte frame -> 2 words, second has tlast=1, tuser=1. Bytes 9-12 dropped. The next frame packs normally.
// - m_tready held 0 for 10 cycles mid-frame -> s_tready drops after one word is held; no byte lost or duplicated; stream resumes at 1 byte/clk once released.
// - Reset asserted after 2 bytes of a frame -> no output. A following 4-byte frame gives exactly one correct word. With STATS_EN: stat_frames_o=1.

Source files
------------

// File: rtl/eth_axis_rx_buffer.sv
// Ethernet RX byte packer: 8-bit AXI-Stream in, 32-bit words (lane 0 first) out.
// Optional frame/error counters enabled by defining ETH_RX_BUFFER_STATS_EN.
module eth_axis_rx_buffer #(
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [1:0]  m_axis_byte_count,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready
`ifdef ETH_RX_BUFFER_STATS_EN
    ,
    input  logic        stat_clr_i,
    output logic [31:0] stat_frames_o,
    output logic [31:0] stat_err_frames_o
`endif
);

    typedef enum logic {
        PACK,
        DISCARD
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_asm;
    logic [1:0]  r_idx;
    logic        r_err;
    logic [15:0] r_len;
    logic [31:0] r_m_data;
    logic [1:0]  r_m_bc;
    logic        r_m_valid;
    logic        r_m_last;
    logic        r_m_user;

    logic        w_s_tready;
    logic        w_acc;
    logic        w_pack_acc;
    logic [15:0] w_len_inc;
    logic        w_trunc;
    logic        w_done;
    logic [31:0] w_word;

    assign s_axis_tready     = w_s_tready;
    assign m_axis_tdata      = r_m_data;
    assign m_axis_byte_count = r_m_bc;
    assign m_axis_tvalid     = r_m_valid;
    assign m_axis_tlast      = r_m_last;
    assign m_axis_tuser      = r_m_user;

    always_comb begin
        w_s_tready = 1'b0;
        if (rstn_i) begin
            if (r_state == DISCARD) w_s_tready = 1'b1;
            else                    w_s_tready = !r_m_valid || m_axis_tready;
        end
    end

    assign w_acc      = s_axis_tvalid && w_s_tready;
    assign w_pack_acc = w_acc && (r_state == PACK);
    assign w_len_inc  = r_len + 16'd1;
    // Reaching the size limit without tlast closes the word as a bad frame.
    assign w_trunc    = !s_axis_tlast && (w_len_inc == MAX_LEN);
    assign w_done     = (r_idx == 2'd3) || s_axis_tlast || w_trunc;

    always_comb begin
        w_word = '0;
        unique case (r_idx)
            2'd0:    w_word = {24'd0, s_axis_tdata};
            2'd1:    w_word = {16'd0, s_axis_tdata, r_asm[7:0]};
            2'd2:    w_word = {8'd0, s_axis_tdata, r_asm[15:0]};
            default: w_word = {s_axis_tdata, r_asm};
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            PACK:    if (w_acc && w_trunc) w_state_nxt = DISCARD;
            DISCARD: if (w_acc && s_axis_tlast) w_state_nxt = PACK;
            default: w_state_nxt = PACK;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) r_state <= PACK;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_asm     <= '0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_len     <= '0;
            r_m_data  <= '0;
            r_m_bc    <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_user  <= 1'b0;
        end else begin
            if (w_pack_acc) begin
                if (w_done) begin
                    r_idx <= '0;
                    r_err <= 1'b0;
                    r_len <= (s_axis_tlast || w_trunc) ? 16'd0 : w_len_inc;
                end else begin
                    unique case (r_idx)
                        2'd0:    r_asm[7:0]   <= s_axis_tdata;
                        2'd1:    r_asm[15:8]  <= s_axis_tdata;
                        default: r_asm[23:16] <= s_axis_tdata;
                    endcase
                    r_idx <= r_idx + 2'd1;
                    r_err <= r_err || s_axis_tuser;
                    r_len <= w_len_inc;
                end
            end else if (w_acc && s_axis_tlast) begin
                r_idx <= '0;
                r_err <= 1'b0;
                r_len <= '0;
            end

            if (w_pack_acc && w_done) begin
                r_m_data  <= w_word;
                r_m_bc    <= r_idx;
                r_m_valid <= 1'b1;
                r_m_last  <= s_axis_tlast || w_trunc;
                r_m_user  <= r_err || s_axis_tuser || w_trunc;
            end else if (m_axis_tready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

`ifdef ETH_RX_BUFFER_STATS_EN
    logic [31:0] r_stat_frames;
    logic [31:0] r_stat_err;
    logic        w_frame_out;

    assign w_frame_out       = r_m_valid && m_axis_tready && r_m_last;
    assign stat_frames_o     = r_stat_frames;
    assign stat_err_frames_o = r_stat_err;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || stat_clr_i) begin
            r_stat_frames <= '0;
            r_stat_err    <= '0;
        end else if (w_frame_out) begin
            r_stat_frames <= r_stat_frames + 32'd1;
            if (r_m_user) r_stat_err <= r_stat_err + 32'd1;
        end
    end
`endif

endmodule
